ps2_mouse_decoder: RTL and testbench
====================================

# ps2_mouse_decoder

Receives the PS/2 serial stream from a mouse, assembles standard 3-byte movement packets, and maintains an absolute, screen-clamped cursor position plus button state. It is the producer side of the GPIO mouse inputs: its `mouse_x`, `mouse_y` and `mouse_click` outputs drive the GPIO block's `Mouse_X`, `Mouse_Y` and `Mouse_Click` inputs directly. The block is receive-only and never drives the PS/2 lines.

## Interface
- `SCREEN_W`, default 640: horizontal range; x is clamped to [0, SCREEN_W-1].
- `SCREEN_H`, default 480: vertical range; y is clamped to [0, SCREEN_H-1].
- `FILTER_LEN`, default 8: number of consecutive equal `clk` samples needed to accept a new ps2_clk level.
- `TIMEOUT`, default 50000: number of `clk` cycles without a falling edge that aborts a frame in progress.
- `clk`  in  1  system clock; the only clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `mouse_x`  out  16  cursor column, unsigned.
- `mouse_y`  out  16  cursor row, unsigned; row 0 is the top of the screen.
- `mouse_click`  out  8  {5'b0, middle, right, left}.
- `pkt_valid`  out  1  one-cycle pulse when a packet is applied.
- `err`  out  1  one-cycle pulse on a frame error or timeout.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. The synchronized clock is then filtered: the filtered level changes only after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock is a sample event, and data is sampled on that event.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: data 0 at a sample event → DATA. Data 1 → stay in IDLE (glitch, no `err`).
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter; after bit 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: stop bit 1 and parity OK → byte accepted. Otherwise → `err`, byte dropped, packet index cleared. Both cases return to IDLE.
- **Watchdog.** A counter runs in any non-IDLE state and clears at each sample event. When it reaches TIMEOUT: `err` pulses, FSM → IDLE, packet index → 0.
- **Packet assembler** (index 0..2):
  - Byte 0 must have bit3 = 1; otherwise it is discarded with no `err` and the index stays 0.
  - Bytes 1 and 2 are dx and dy.
  - Byte 0 fields: bits [2:0] buttons, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- **Position update** on byte 2, in 18-bit signed arithmetic:
  - dx = {Xsign, byte1} sign-extended; dx = 0 if X overflow is set.
  - dy is formed the same way from Ysign, byte2 and Y overflow.
  - x_new = x + dx; y_new = y − dy (PS/2 +Y is up, screen +Y is down).
  - Each result is clamped independently: below 0 → 0; above max → max.
  - `mouse_x`, `mouse_y`, `mouse_click` and `pkt_valid` all update in the same cycle.
- **Reset values:** `mouse_x` = SCREEN_W/2, `mouse_y` = SCREEN_H/2, `mouse_click` = 0, `pkt_valid` = 0, `err` = 0, FSM = IDLE, packet index = 0, all counters 0.
- **Reset mid-frame:** all partial byte and packet state is discarded.

## Timing
- Sample event latency: 2 sync cycles + FILTER_LEN cycles after the raw falling edge.
- Outputs are registered. They update, and `pkt_valid` is high, on the cycle after the STOP sample event of byte 2.
- `pkt_valid` and `err` are single-cycle pulses and are never high in the same cycle.
- A new start bit is accepted in the cycle after STOP; back-to-back frames are supported.
- A timeout and a sample event in the same cycle: the sample event wins and the watchdog clears.
- Outputs hold their values between packets. There is no handshake; the consumer samples at any time.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: odd parity is checked (data bits XOR parity bit must be 1). A mismatch causes an `err` pulse and drops the byte.
  - Undefined: the parity bit is captured but ignored, and only the stop bit is checked.

## Test plan
- Reset asserted → `mouse_x` = 320, `mouse_y` = 240, `mouse_click` = 0, `pkt_valid` = 0, `err` = 0.
- Frames 0x09, 0x05, 0x03 with correct parity → exactly one `pkt_valid` pulse; `mouse_x` = 325, `mouse_y` = 237, `mouse_click` = 0x01.
- From reset, send 0x38/0x00/0x00 twice (X and Y negative, dx = dy = −256):
  - After packet 1: x = 64, y = 479 (clamped).
  - After packet 2: x = 0, y = 479.
- With `PS2_PARITY_CHECK_EN` defined, corrupt parity in byte 1 → one `err` pulse and no `pkt_valid`. A following valid 0x08, 0x01, 0x00 packet → x = 321.
- Byte 0x00 (bit3 = 0) sent before a valid packet → no `err` and no update; the valid packet still decodes correctly.
- 5 bits of a frame, then the line held high for TIMEOUT+10 cycles → one `err` pulse at TIMEOUT. The next full packet is applied normally.

Source files
------------

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse receiver: conditions the raw lines, frames bytes, assembles 3-byte packets
// and keeps a screen-clamped cursor. Optional odd-parity check: PS2_PARITY_CHECK_EN.
module ps2_mouse_decoder #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic [15:0] mouse_y,
  output logic [7:0]  mouse_click,
  output logic        pkt_valid,
  output logic        err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic [15:0] clamp(input logic signed [17:0] v, input int maxv);
    if (v < 0)
      return 16'd0;
    else if (v > maxv)
      return 16'(maxv);
    else
      return v[15:0];
  endfunction

  state_t            r_state, w_state_nx;
  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic              r_filt;
  logic [FW-1:0]     r_filt_cnt;
  logic [2:0]        r_bit_cnt;
  logic [WW-1:0]     r_wd;
  logic [1:0]        r_idx;
  logic [7:0]        r_shift, r_b1;
  logic [2:0]        r_btn, r_btn_out;
  logic              r_xs, r_ys, r_xo, r_yo;
  logic              w_sample, w_byte_ok, w_frame_err, w_timeout, w_par_ok, w_apply;
  logic signed [17:0] w_dx, w_dy, w_x_sum, w_y_sum;

  // Sample event coincides with the filtered clock accepting a new low level
  assign w_sample = r_filt && !r_clk_s2 && (r_filt_cnt == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = (^r_shift) ^ r_par;
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    w_timeout   = 1'b0;
    if (w_sample) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nx = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nx = S_PARITY;
        S_PARITY: w_state_nx = S_STOP;
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (r_dat_s2 && w_par_ok) w_byte_ok   = 1'b1;
          else                      w_frame_err = 1'b1;
        end
        default:  w_state_nx = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_wd == WW'(TIMEOUT)) begin
      w_timeout  = 1'b1;
      w_state_nx = S_IDLE;
    end
  end

  assign w_apply = w_byte_ok && (r_idx == 2'd2);
  assign w_dx    = r_xo ? 18'sd0 : {{9{r_xs}}, r_xs, r_b1};
  assign w_dy    = r_yo ? 18'sd0 : {{9{r_ys}}, r_ys, r_shift};
  assign w_x_sum = $signed({2'b00, mouse_x}) + w_dx;
  assign w_y_sum = $signed({2'b00, mouse_y}) - w_dy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_bit_cnt  <= '0;
      r_wd       <= '0;
      r_idx      <= '0;
      r_btn_out  <= '0;
      mouse_x    <= 16'(SCREEN_W / 2);
      mouse_y    <= 16'(SCREEN_H / 2);
      pkt_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;

      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end

      if (w_timeout || r_state == S_IDLE)
        r_bit_cnt <= '0;
      else if (w_sample && r_state == S_DATA)
        r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_sample || w_timeout || r_state == S_IDLE)
        r_wd <= '0;
      else
        r_wd <= r_wd + 1'b1;

      // Any framing failure abandons the packet being assembled
      if (w_frame_err || w_timeout) begin
        r_idx <= 2'd0;
      end else if (w_byte_ok) begin
        case (r_idx)
          2'd0:    if (r_shift[3]) r_idx <= 2'd1;
          2'd1:    r_idx <= 2'd2;
          default: r_idx <= 2'd0;
        endcase
      end

      if (w_apply) begin
        mouse_x   <= clamp(w_x_sum, SCREEN_W - 1);
        mouse_y   <= clamp(w_y_sum, SCREEN_H - 1);
        r_btn_out <= r_btn;
      end
      pkt_valid <= w_apply;
      err       <= w_frame_err || w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sample && r_state == S_DATA)
      r_shift <= {r_dat_s2, r_shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
    if (w_sample && r_state == S_PARITY)
      r_par <= r_dat_s2;
`endif
    if (w_byte_ok && r_idx == 2'd0) begin
      r_btn <= r_shift[2:0];
      r_xs  <= r_shift[4];
      r_ys  <= r_shift[5];
      r_xo  <= r_shift[6];
      r_yo  <= r_shift[7];
    end
    if (w_byte_ok && r_idx == 2'd1)
      r_b1 <= r_shift;
  end

  assign mouse_click = {5'b0, r_btn_out};

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: directed cases plus random packets against an
// arithmetic cursor model.
module tb_ps2_mouse_decoder;

  localparam int TOUT = 2000;
  localparam int HALF = 20;
  localparam int GAP  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] mouse_x, mouse_y;
  logic [7:0]  mouse_click;
  logic        pkt_valid, err;

  int n_total = 0;
  int n_bad   = 0;
  int n_pkt   = 0;
  int n_err   = 0;
  int n_both  = 0;
  int mx, my, mbtn;

  ps2_mouse_decoder #(.SCREEN_W(640), .SCREEN_H(480), .FILTER_LEN(8), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_click(mouse_click),
    .pkt_valid(pkt_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid) n_pkt++;
      if (err) n_err++;
      if (pkt_valid && err) n_both++;
    end
  end

  task automatic chk_val(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    @(negedge clk);
    rst = 1'b0;
    mx = 320; my = 240; mbtn = 0;
    wait_clk(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(GAP);
  endtask

  function automatic int clampi(input int v, input int maxv);
    if (v < 0) return 0;
    if (v > maxv) return maxv;
    return v;
  endfunction

  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx   = clampi(mx + dx, 639);
    my   = clampi(my - dy, 479);
    mbtn = int'(b0[2:0]);
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int p0, e0;
    p0 = n_pkt; e0 = n_err;
    send_byte(b0, 0, 0, 11);
    send_byte(b1, 0, 0, 11);
    send_byte(b2, 0, 0, 11);
    model_pkt(b0, b1, b2);
    chk_val({tag, "_pkt"}, n_pkt - p0, 1);
    chk_val({tag, "_err"}, n_err - e0, 0);
    chk_val({tag, "_x"}, mouse_x, mx);
    chk_val({tag, "_y"}, mouse_y, my);
    chk_val({tag, "_click"}, mouse_click, mbtn);
  endtask

  initial begin
    int p0, e0;
    logic [7:0] b0, b1, b2, junk;

    wait_clk(2);
    chk_val("rst_x", mouse_x, 320);
    chk_val("rst_y", mouse_y, 240);
    chk_val("rst_click", mouse_click, 0);
    chk_val("rst_pkt", pkt_valid, 0);
    chk_val("rst_err", err, 0);
    do_reset();

    run_pkt("basic", 8'h09, 8'h05, 8'h03);
    chk_val("basic_x_abs", mouse_x, 325);
    chk_val("basic_y_abs", mouse_y, 237);
    chk_val("basic_click_abs", mouse_click, 8'h01);

    do_reset();
    run_pkt("neg1", 8'h38, 8'h00, 8'h00);
    chk_val("neg1_x_abs", mouse_x, 64);
    chk_val("neg1_y_abs", mouse_y, 479);
    run_pkt("neg2", 8'h38, 8'h00, 8'h00);
    chk_val("neg2_x_abs", mouse_x, 0);
    chk_val("neg2_y_abs", mouse_y, 479);

    do_reset();
    p0 = n_pkt; e0 = n_err;
    send_byte(8'h08, 0, 0, 11);
`ifdef PS2_PARITY_CHECK_EN
    send_byte(8'h01, 1, 0, 11);
`else
    send_byte(8'h01, 0, 1, 11);
`endif
    send_byte(8'h00, 0, 0, 11);
    chk_val("bad_err", n_err - e0, 1);
    chk_val("bad_pkt", n_pkt - p0, 0);
    chk_val("bad_x_hold", mouse_x, 320);
    run_pkt("after_bad", 8'h08, 8'h01, 8'h00);
    chk_val("after_bad_x_abs", mouse_x, 321);

    e0 = n_err; p0 = n_pkt;
    send_byte(8'h00, 0, 0, 11);
    chk_val("junk_err", n_err - e0, 0);
    chk_val("junk_pkt", n_pkt - p0, 0);
    run_pkt("after_junk", 8'h08, 8'h05, 8'h00);
    chk_val("after_junk_x_abs", mouse_x, 326);

    e0 = n_err; p0 = n_pkt;
    send_byte(8'h5A, 0, 0, 5);
    wait_clk(TOUT + 10);
    chk_val("tout_err", n_err - e0, 1);
    chk_val("tout_pkt", n_pkt - p0, 0);
    run_pkt("after_tout", 8'h0A, 8'h10, 8'hF0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom) & 8'hF7;
        e0 = n_err; p0 = n_pkt;
        send_byte(junk, 0, 0, 11);
        chk_val("rnd_junk_quiet", (n_err - e0) + (n_pkt - p0), 0);
      end
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      run_pkt("rnd", b0, b1, b2);
    end

    chk_val("pulse_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
